branch_predictor: RTL and testbench
===================================

# branch_predictor

Gshare direction predictor for the five-stage MIPS pipeline: looks up a taken/not-taken prediction for the instruction fetched in IF and presents it, registered, in ID. It is trained in EX by the resolved outcome from the branch condition logic (BEQ/BNE/BGTZ/BLEZ/BGEZ/BGEZAL/BLTZ/BLTZAL). It also reports mispredictions and keeps branch/mispredict counters. Branch targets are computed in ID, so no BTB is held here.

## Interface
- INDEX_BITS, 6: log2 of pattern history table (PHT) entries; also the global history register (GHR) width.
- CNT_WIDTH, 32: width of the statistics counters.

- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- if_valid  in  1  IF holds a valid fetch PC this cycle.
- if_pc  in  32  fetch PC.
- id_stall  in  1  ID is stalled; hold all pred_* outputs.
- flush  in  1  squash the ID-stage prediction.
- pred_valid  out  1  pred_* outputs correspond to the instruction now in ID.
- pred_taken  out  1  predicted direction.
- pred_index  out  INDEX_BITS  PHT index used; carried down the pipe to EX.
- upd_valid  in  1  a conditional branch resolved in EX this cycle.
- upd_index  in  INDEX_BITS  pred_index carried with that branch.
- upd_taken  in  1  resolved direction from the branch condition logic.
- upd_pred  in  1  pred_taken carried with that branch.
- mispredict  out  1  registered; upd_taken differed from upd_pred.
- branch_cnt  out  CNT_WIDTH  resolved-branch count.
- mispred_cnt  out  CNT_WIDTH  misprediction count.

## Operation
- Storage:
  - PHT: 2^INDEX_BITS entries of 2-bit saturating counters (SNT=00, WNT=01, WT=10, ST=11).
  - GHR: INDEX_BITS-bit shift register of resolved outcomes.
- Lookup index: if_pc[INDEX_BITS+1:2] XOR GHR (current GHR value).
- Prediction: taken iff the counter MSB is 1.
- Update, when upd_valid:
  - Counter at upd_index: +1 saturating at 11 if upd_taken, else -1 saturating at 00.
  - GHR <= {GHR[INDEX_BITS-2:0], upd_taken}.
  - branch_cnt increments.
  - mispred_cnt increments and mispredict pulses iff upd_taken != upd_pred.
- Counters wrap modulo 2^CNT_WIDTH.
- Bypass: if an update and a lookup in the same cycle hit the same index, the lookup uses the post-update counter value. The GHR used for that lookup is still the pre-update value.
- Reset:
  - All PHT entries reset to WNT (01); GHR = 0.
  - pred_valid, pred_taken, mispredict = 0; pred_index = 0; both counters = 0.
  - An asserted resetn mid-operation discards any in-flight update.

## Timing
- Prediction latency is 1 cycle. if_valid/if_pc sampled at edge N give pred_* valid from N until the next edge.
- id_stall=1: all pred_* outputs hold. The lookup is not re-registered, and IF keeps presenting the same PC.
- flush=1: pred_valid <= 0 at the next edge, regardless of id_stall. flush has priority over stall and over a new lookup.
- Updates are never stalled. A PHT, GHR or counter change is visible from the next edge, except for the same-cycle PHT bypass above.
- mispredict is registered: high for exactly one cycle after the edge at which the mispredicting update was sampled.
- At most one update per cycle. upd_* are ignored when upd_valid=0.

## Structure
- Package bp_pkg:
  - typedef enum logic[1:0] for counter states SNT/WNT/WT/ST.
  - functions sat_inc/sat_dec.
  - localparam for the reset counter value.
- Sub-module bp_pht: counter array with one combinational read port, one write port, async reset and the same-index bypass.
- Top level holds the GHR, index hash, ID output register, mispredict flag and statistics counters.

## Test plan
- Reset then lookup:
  - resetn low, release, if_valid=1, if_pc=0x00400010.
  - Next cycle: pred_valid=1, pred_taken=0, pred_index=0x04.
- Saturation:
  - Four updates to index 5, all taken. Counter goes 01→10→11→11→11; lookups of index 5 predict taken.
  - Then three not-taken updates: counter ends at 00.
- Same-index bypass:
  - Counter at index 3 = WNT. In one cycle, upd taken to index 3 and lookup hashing to 3.
  - Next cycle: pred_taken=1.
- Mispredict accounting:
  - Sequence of 5 updates with upd_pred/upd_taken = (0,1), (1,1), (1,0), (0,0), (0,1).
  - mispredict pulses after updates 1, 3 and 5; branch_cnt=5, mispred_cnt=3.
- Stall/flush:
  - With pred_valid=1 and pred_taken=1, hold id_stall for 3 cycles: outputs unchanged.
  - flush together with id_stall: pred_valid=0 next cycle.
- GHR hashing:
  - After updates taken, not-taken, taken (GHR=0b000101), lookup if_pc=0x00400010.
  - pred_index = 0x04 XOR 0x05 = 0x01.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare predictor: 2-bit counter states
// and their saturating step functions.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;

    function automatic ctr_e sat_inc(input ctr_e c);
        case (c)
            SNT:     return WNT;
            WNT:     return WT;
            default: return ST;
        endcase
    endfunction

    function automatic ctr_e sat_dec(input ctr_e c);
        case (c)
            ST:      return WT;
            WT:      return WNT;
            default: return SNT;
        endcase
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2-bit counters, one combinational read port, one
// write port, and a same-index bypass so a read sees the counter being written.
module bp_pht
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [INDEX_BITS-1:0] rd_index,
    output ctr_e                  rd_ctr,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  wr_taken
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    ctr_e ctr_q [ENTRIES];
    ctr_e ctr_d [ENTRIES];
    ctr_e wr_ctr;

    always_comb begin
        wr_ctr = wr_taken ? sat_inc(ctr_q[wr_index]) : sat_dec(ctr_q[wr_index]);
        ctr_d  = ctr_q;
        if (wr_en) begin
            ctr_d[wr_index] = wr_ctr;
        end
        rd_ctr = (wr_en && (wr_index == rd_index)) ? wr_ctr : ctr_q[rd_index];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor: IF-stage lookup registered into ID, EX-stage
// training, misprediction flag and branch/mispredict statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  if_valid,
    input  logic [31:0]           if_pc,
    input  logic                  id_stall,
    input  logic                  flush,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    input  logic                  upd_pred,
    output logic                  mispredict,
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispred_cnt
);

    logic [INDEX_BITS-1:0] ghr_q, ghr_d;
    logic [INDEX_BITS-1:0] lookup_index;
    ctr_e                  rd_ctr;
    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
    logic                  mispredict_q, mispredict_d;
    logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^{if_pc[31:INDEX_BITS+2], if_pc[1:0]};
    assign lookup_index   = if_pc[INDEX_BITS+1:2] ^ ghr_q;

    bp_pht #(.INDEX_BITS(INDEX_BITS)) u_pht (
        .clk      (clk),
        .resetn   (resetn),
        .rd_index (lookup_index),
        .rd_ctr   (rd_ctr),
        .wr_en    (upd_valid),
        .wr_index (upd_index),
        .wr_taken (upd_taken)
    );

    // upd_* are qualified by upd_valid alone; there is no back-pressure, so
    // training is never stalled. flush beats stall, which beats a new lookup.
    always_comb begin
        pred_valid_d  = pred_valid_q;
        pred_taken_d  = pred_taken_q;
        pred_index_d  = pred_index_q;
        if (flush) begin
            pred_valid_d = 1'b0;
        end else if (!id_stall) begin
            pred_valid_d = if_valid;
            pred_taken_d = rd_ctr[1];
            pred_index_d = lookup_index;
        end

        ghr_d         = ghr_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        mispredict_d  = upd_valid && (upd_taken != upd_pred);
        if (upd_valid) begin
            ghr_d        = {ghr_q[INDEX_BITS-2:0], upd_taken};
            branch_cnt_d = branch_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        if (mispredict_d) begin
            mispred_cnt_d = mispred_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ghr_q         <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_index_q  <= '0;
            mispredict_q  <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            ghr_q         <= ghr_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_index_q  <= pred_index_d;
            mispredict_q  <= mispredict_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_index  = pred_index_q;
    assign mispredict  = mispredict_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, saturation, bypass, mispredict
// accounting, stall/flush and GHR hashing, checked with immediate assertions.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        id_stall;
    logic        flush;
    logic        pred_valid;
    logic        pred_taken;
    logic [5:0]  pred_index;
    logic        upd_valid;
    logic [5:0]  upd_index;
    logic        upd_taken;
    logic        upd_pred;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_ghr = 6'h0;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(6), .CNT_WIDTH(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .id_stall    (id_stall),
        .flush       (flush),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_index  (pred_index),
        .upd_valid   (upd_valid),
        .upd_index   (upd_index),
        .upd_taken   (upd_taken),
        .upd_pred    (upd_pred),
        .mispredict  (mispredict),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set before the edge, outputs sampled 1 ns after it.
    task automatic cyc();
        @(posedge clk);
        if (upd_valid) exp_ghr = {exp_ghr[4:0], upd_taken};
        #1;
    endtask

    // PC whose hashed index equals idx under the current global history.
    function automatic logic [31:0] pc_for(input logic [5:0] idx);
        return 32'h0040_0000 | {24'h0, idx ^ exp_ghr, 2'b00};
    endfunction

    task automatic sat_step(input string tag, input logic upd, input logic t, input logic exp_t);
        upd_valid = upd;
        upd_index = 6'd5;
        upd_taken = t;
        upd_pred  = t;
        if_valid  = 1'b1;
        if_pc     = pc_for(6'd5);
        cyc();
        chk({tag, "_taken"}, pred_taken, exp_t);
        chk({tag, "_index"}, pred_index, 6'd5);
        chk({tag, "_mispred"}, mispredict, 1'b0);
    endtask

    task automatic mis_step(input string tag, input logic p, input logic t, input logic exp_m);
        upd_valid = 1'b1;
        upd_index = 6'd10;
        upd_pred  = p;
        upd_taken = t;
        cyc();
        chk(tag, mispredict, exp_m);
    endtask

    initial begin
        resetn = 1'b0; if_valid = 1'b0; if_pc = 32'h0; id_stall = 1'b0; flush = 1'b0;
        upd_valid = 1'b0; upd_index = 6'h0; upd_taken = 1'b0; upd_pred = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pred_valid", pred_valid, 1'b0);
        chk("rst_pred_taken", pred_taken, 1'b0);
        chk("rst_pred_index", pred_index, 6'h0);
        chk("rst_mispredict", mispredict, 1'b0);
        chk("rst_branch_cnt", branch_cnt, 32'd0);
        chk("rst_mispred_cnt", mispred_cnt, 32'd0);
        resetn = 1'b1;

        // First lookup after reset: WNT, index 0x04
        if_valid = 1'b1; if_pc = 32'h0040_0010;
        cyc();
        chk("first_valid", pred_valid, 1'b1);
        chk("first_taken", pred_taken, 1'b0);
        chk("first_index", pred_index, 6'h04);

        // Saturation at index 5 (same-cycle lookup sees the bypassed counter)
        sat_step("sat_up1", 1'b1, 1'b1, 1'b1);   // 01 -> 10
        sat_step("sat_up2", 1'b1, 1'b1, 1'b1);   // 10 -> 11
        sat_step("sat_up3", 1'b1, 1'b1, 1'b1);   // 11 -> 11
        sat_step("sat_up4", 1'b1, 1'b1, 1'b1);   // 11 -> 11
        sat_step("sat_hold", 1'b0, 1'b0, 1'b1);  // read 11
        sat_step("sat_dn1", 1'b1, 1'b0, 1'b1);   // 11 -> 10
        sat_step("sat_dn2", 1'b1, 1'b0, 1'b0);   // 10 -> 01
        sat_step("sat_dn3", 1'b1, 1'b0, 1'b0);   // 01 -> 00
        sat_step("sat_low", 1'b0, 1'b0, 1'b0);   // read 00
        sat_step("sat_rise", 1'b1, 1'b1, 1'b0);  // 00 -> 01, still not taken

        // Bypass: WNT at index 3 trained taken while being looked up
        upd_valid = 1'b1; upd_index = 6'd3; upd_taken = 1'b1; upd_pred = 1'b1;
        if_valid = 1'b1; if_pc = pc_for(6'd3);
        cyc();
        chk("byp_taken", pred_taken, 1'b1);
        chk("byp_index", pred_index, 6'd3);
        if_pc = pc_for(6'd7);
        cyc();
        chk("byp_other_taken", pred_taken, 1'b0);
        chk("byp_other_index", pred_index, 6'd7);

        // Mispredict accounting
        if_valid = 1'b0;
        mis_step("mis_1", 1'b0, 1'b1, 1'b1);
        mis_step("mis_2", 1'b1, 1'b1, 1'b0);
        mis_step("mis_3", 1'b1, 1'b0, 1'b1);
        mis_step("mis_4", 1'b0, 1'b0, 1'b0);
        mis_step("mis_5", 1'b0, 1'b1, 1'b1);
        upd_valid = 1'b0; upd_pred = 1'b1; upd_taken = 1'b0;
        cyc();
        chk("mis_idle", mispredict, 1'b0);
        chk("branch_cnt", branch_cnt, 32'd15);
        chk("mispred_cnt", mispred_cnt, 32'd3);

        // Stall holds outputs; flush wins over stall and over a lookup
        if_valid = 1'b1; if_pc = pc_for(6'd3);
        cyc();
        chk("pre_stall_valid", pred_valid, 1'b1);
        chk("pre_stall_taken", pred_taken, 1'b1);
        id_stall = 1'b1; if_pc = pc_for(6'd7);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_valid", pred_valid, 1'b1);
            chk("stall_taken", pred_taken, 1'b1);
            chk("stall_index", pred_index, 6'd3);
        end
        flush = 1'b1;
        cyc();
        chk("flush_stall_valid", pred_valid, 1'b0);
        flush = 1'b0; id_stall = 1'b0;
        cyc();
        chk("resume_valid", pred_valid, 1'b1);
        chk("resume_taken", pred_taken, 1'b0);
        chk("resume_index", pred_index, 6'd7);
        flush = 1'b1;
        cyc();
        chk("flush_lookup_valid", pred_valid, 1'b0);
        flush = 1'b0; if_valid = 1'b0;

        // Reset mid-operation discards the in-flight update
        upd_valid = 1'b1; upd_index = 6'd3; upd_taken = 1'b0; upd_pred = 1'b1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        exp_ghr = 6'h0;
        chk("midrst_branch_cnt", branch_cnt, 32'd0);
        chk("midrst_mispred_cnt", mispred_cnt, 32'd0);
        chk("midrst_mispredict", mispredict, 1'b0);
        chk("midrst_pred_valid", pred_valid, 1'b0);
        upd_valid = 1'b0;
        resetn = 1'b1;

        // GHR hashing: T, NT, T -> GHR = 0b000101
        upd_index = 6'd20;
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pred = 1'b1; cyc();
        upd_valid = 1'b1; upd_taken = 1'b0; upd_pred = 1'b0; cyc();
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pred = 1'b1; cyc();
        upd_valid = 1'b0;
        if_valid = 1'b1; if_pc = 32'h0040_0010;
        cyc();
        chk("ghr_index", pred_index, 6'h01);
        chk("ghr_taken", pred_taken, 1'b0);
        if_pc = 32'h0040_0018;   // pc bits 0x06 ^ 0x05 = 0x03, counter back at WNT
        cyc();
        chk("ghr_idx3_index", pred_index, 6'h03);
        chk("ghr_idx3_taken", pred_taken, 1'b0);
        chk("ghr_branch_cnt", branch_cnt, 32'd3);
        chk("ghr_mispred_cnt", mispred_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
